// File: rtl/wishbone_fifo_port_pkg.sv
// wishbone_fifo_port_pkg: register map, STATUS/CTRL bit positions and reset
// values shared by the Wishbone FIFO port and its testbench.
package wishbone_fifo_port_pkg;

    // Register select taken from byte address bits [3:2]
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    localparam logic [3:0] OFS_DATA   = 4'h0;
    localparam logic [3:0] OFS_STATUS = 4'h4;
    localparam logic [3:0] OFS_CTRL   = 4'h8;
    localparam logic [3:0] OFS_RSVD   = 4'hC;

    localparam int STAT_OVF_BIT   = 31;
    localparam int STAT_FULL_BIT  = 17;
    localparam int STAT_EMPTY_BIT = 16;
    localparam int STAT_COUNT_W   = 16;

    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT  = 2;

    localparam logic        RST_ACK    = 1'b0;
    localparam logic [31:0] RST_DAT    = 32'h0;
    localparam logic        RST_OVF    = 1'b0;
    localparam logic        RST_IRQ_EN = 1'b0;
    localparam logic        RST_IRQ    = 1'b0;

endpackage

// File: rtl/wishbone_fifo_port_fifo_core.sv
// fifo_core: circular-buffer FIFO with push, pop and synchronous flush.
// Storage is deliberately left out of reset; only pointers and count clear.
module fifo_core #(
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DW-1:0]            head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage write; no reset so the array maps onto plain RAM
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush overrides any same-edge push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/wishbone_fifo_port.sv
// wishbone_fifo_port: Wishbone classic slave that pushes DATA writes into a
// FIFO drained by a valid/ready stream. Registers: DATA, STATUS, CTRL.
// Optional interrupt output enabled by defining WISHBONE_FIFO_PORT_IRQ_EN.
module wishbone_fifo_port
    import wishbone_fifo_port_pkg::*;
#(
    parameter int          DW       = 32,
    parameter int          DEPTH    = 16,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
`ifdef WISHBONE_FIFO_PORT_IRQ_EN
    ,
    parameter int          IRQ_THRESH = DEPTH / 2
`endif
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [DW-1:0] m_data_o
`ifdef WISHBONE_FIFO_PORT_IRQ_EN
    ,
    output logic          irq_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          hit;
    logic          access;
    reg_sel_e      sel;
    logic          wr_data;
    logic          wr_ctrl;
    logic          push;
    logic          pop;
    logic          flush;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          irq_en;
    logic [31:0]   rdata;
    logic          unused_bits;

    // Side effects fire only on the edge where ack rises, once per access
    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign access  = hit & ~wbs_ack_o;
    assign sel     = reg_sel_e'(wbs_adr_i[3:2]);
    assign wr_data = access & wbs_we_i & (sel == REG_DATA);
    assign wr_ctrl = access & wbs_we_i & (sel == REG_CTRL);
    assign pop     = m_valid_o & m_ready_i;
    assign push    = wr_data & (~full | pop);
    assign flush   = wr_ctrl & wbs_dat_i[CTRL_FLUSH_BIT];

    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i};

    fifo_core #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo_core (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (push),
        .push_data (wbs_dat_i[DW-1:0]),
        .pop       (pop),
        .flush     (flush),
        .head      (m_data_o),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign m_valid_o = ~empty;

    // Read-data mux; DATA and the reserved slot read as zero
    always_comb begin
        rdata = '0;
        case (sel)
            REG_STATUS: begin
                rdata[STAT_OVF_BIT]            = overflow;
                rdata[STAT_FULL_BIT]           = full;
                rdata[STAT_EMPTY_BIT]          = empty;
                rdata[STAT_COUNT_W-1:0]        = STAT_COUNT_W'(count);
            end
            REG_CTRL:   rdata[CTRL_IRQ_EN_BIT] = irq_en;
            default:    rdata = '0;
        endcase
    end

    // Ack handshake, registered read data and sticky overflow flag
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= RST_ACK;
            wbs_dat_o <= RST_DAT;
            overflow  <= RST_OVF;
        end else begin
            wbs_ack_o <= access;
            wbs_dat_o <= (access && !wbs_we_i) ? rdata : '0;
            if (wr_ctrl && wbs_dat_i[CTRL_CLR_OVF_BIT]) begin
                overflow <= 1'b0;
            end else if (wr_data && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef WISHBONE_FIFO_PORT_IRQ_EN
    // Interrupt enable and registered interrupt level
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_en <= RST_IRQ_EN;
            irq_o  <= RST_IRQ;
        end else begin
            if (wr_ctrl) irq_en <= wbs_dat_i[CTRL_IRQ_EN_BIT];
            irq_o <= irq_en & ((count >= CW'(IRQ_THRESH)) | overflow);
        end
    end
`else
    assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_fifo_port.sv
// tb_wishbone_fifo_port: directed scenarios plus randomized register traffic
// against a queue-based model of the FIFO port. IRQ scenarios are built only
// when WISHBONE_FIFO_PORT_IRQ_EN is defined.
module tb_wishbone_fifo_port;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat_o;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [31:0] q[$];
    logic        ovf    = 1'b0;
    logic        irq_en = 1'b0;

    // snapshots taken on the half cycle after an access's ack edge
    logic        mv_after;
    logic [31:0] md_after;
    logic        irq_after;

    always #5 clk = ~clk;

`ifdef WISHBONE_FIFO_PORT_IRQ_EN
    wishbone_fifo_port #(.DW(32), .DEPTH(DEPTH), .BASE_ADR(BASE), .IRQ_THRESH(8)) dut (
`else
    wishbone_fifo_port #(.DW(32), .DEPTH(DEPTH), .BASE_ADR(BASE)) dut (
`endif
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat_o),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (m_data)
`ifdef WISHBONE_FIFO_PORT_IRQ_EN
        ,
        .irq_o     (irq)
`endif
    );
`ifndef WISHBONE_FIFO_PORT_IRQ_EN
    assign irq = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n = q.size();
        return {ovf, 13'b0, logic'(n == DEPTH), logic'(n == 0), 16'(n)};
    endfunction

    // One Wishbone classic access with bounded wait for ack
    task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic rdy, output logic [31:0] rd);
        int  n = 0;
        logic got = 1'b0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; m_ready = rdy;
        while (!got && n < 8) begin
            @(posedge clk); #1;
            n++;
            if (ack) got = 1'b1;
        end
        rd = rdat_o;
        check("ack_latency", n, 1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; m_ready = 1'b0;
        mv_after = m_valid; md_after = m_data; irq_after = irq;
        @(posedge clk); #1;
        check("ack_drop", {31'b0, ack}, 0);
        check("dat_idle", rdat_o, 0);
    endtask

    task automatic reg_write(input logic [3:0] ofs, input logic [31:0] d, input logic rdy);
        logic [31:0] rd;
        logic full_before = (q.size() == DEPTH);
        logic popped = rdy && (q.size() > 0);
        if (popped) check("pop_head", m_data, q[0]);
        wb_cycle(BASE | {28'b0, ofs}, 1'b1, d, rdy, rd);
        if (popped) void'(q.pop_front());
        if (ofs == 4'h0) begin
            if (!full_before || popped) q.push_back(d);
            else ovf = 1'b1;
        end else if (ofs == 4'h8) begin
            if (d[0]) q.delete();
            if (d[1]) ovf = 1'b0;
`ifdef WISHBONE_FIFO_PORT_IRQ_EN
            irq_en = d[2];
`endif
        end
    endtask

    task automatic reg_read(input logic [3:0] ofs, output logic [31:0] rd);
        logic [31:0] exp;
        case (ofs)
            4'h4:    exp = exp_status();
            4'h8:    exp = {29'b0, irq_en, 2'b0};
            default: exp = 32'h0;
        endcase
        wb_cycle(BASE | {28'b0, ofs}, 1'b0, 32'h0, 1'b0, rd);
        check($sformatf("read_%h", ofs), rd, exp);
    endtask

    task automatic drain(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            m_ready = 1'b1;
            check("drain_valid", {31'b0, m_valid}, 1);
            check("drain_data", m_data, q[0]);
            @(posedge clk);
            void'(q.pop_front());
        end
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic wb_noack(input logic [31:0] a, input logic w);
        logic seen = 1'b0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = 32'hDEAD_BEEF;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack) seen = 1'b1;
        end
        check("no_ack", {31'b0, seen}, 0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, ack}, 0);
        check("rst_dat", rdat_o, 0);
        check("rst_valid", {31'b0, m_valid}, 0);
        @(negedge clk);
        rst = 1'b0;

        // single write, one-cycle visibility
        reg_write(4'h0, 32'h0000_00A5, 1'b0);
        check("a5_valid", {31'b0, mv_after}, 1);
        check("a5_data", md_after, 32'hA5);
        reg_read(4'h4, rd);
        check("a5_status", rd, 32'h0000_0001);
        drain(1);

        // overfill: 17 writes, stream yields first 16
        for (int i = 0; i < 17; i++) reg_write(4'h0, 32'h100 + i, 1'b0);
        reg_read(4'h4, rd);
        check("full_status", rd, 32'h8002_0010);
        for (int i = 0; i < 16; i++) check("order", q[i], 32'h100 + i);
        drain(16);

        // full with simultaneous pop: accepted, no overflow
        reg_write(4'h8, 32'h2, 1'b0);
        for (int i = 0; i < 16; i++) reg_write(4'h0, $urandom, 1'b0);
        reg_write(4'h0, 32'h5555_AAAA, 1'b1);
        reg_read(4'h4, rd);
        check("full_pop_status", rd, 32'h0002_0010);
        drain(16);

        // flush + clear overflow
        for (int i = 0; i < 5; i++) reg_write(4'h0, $urandom, 1'b0);
        reg_write(4'h8, 32'h3, 1'b0);
        check("flush_valid", {31'b0, mv_after}, 0);
        reg_read(4'h4, rd);
        check("flush_status", rd, 32'h0001_0000);

        // out-of-window access and reset mid-access
        wb_noack(BASE + 32'h20, 1'b1);
        wb_noack(BASE + 32'h20, 1'b0);
        reg_write(4'h0, 32'h77, 1'b0);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; wdat = 32'h99;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_abort_ack", {31'b0, ack}, 0);
        check("rst_abort_valid", {31'b0, m_valid}, 0);
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        q.delete(); ovf = 1'b0; irq_en = 1'b0;
        @(posedge clk); #1;
        check("rst_abort_ack2", {31'b0, ack}, 0);
        reg_read(4'h4, rd);
        check("rst_status", rd, 32'h0001_0000);

`ifdef WISHBONE_FIFO_PORT_IRQ_EN
        // threshold interrupt
        reg_write(4'h8, 32'h4, 1'b0);
        reg_read(4'h8, rd);
        for (int i = 0; i < 7; i++) reg_write(4'h0, $urandom, 1'b0);
        @(posedge clk); #1;
        check("irq_below", {31'b0, irq}, 0);
        reg_write(4'h0, $urandom, 1'b0);
        check("irq_push_edge", {31'b0, irq_after}, 0);
        check("irq_after", {31'b0, irq}, 1);
        reg_write(4'h8, 32'h1, 1'b0);
        @(posedge clk); #1;
        check("irq_off", {31'b0, irq}, 0);
`endif

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: reg_write(4'h0, $urandom, logic'($urandom_range(0, 3) == 0));
                4:          reg_read(4'h4, rd);
                5:          drain($urandom_range(0, q.size()));
                6:          reg_write(4'h8, 32'($urandom_range(0, 7)) & ((q.size() > 10) ? 32'h7 : 32'h6), 1'b0);
                7:          reg_read(4'h0, rd);
                8:          begin
                                reg_write(4'hC, $urandom, 1'b0);
                                reg_read(4'hC, rd);
                            end
                default:    reg_read(4'h8, rd);
            endcase
            reg_read(4'h4, rd);
        end
        drain(q.size());
        reg_read(4'h4, rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
